fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/isa_shared.sv | 14 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_shared.sv
// Shared definitions for the instruction fetch path.
//   fetch_state_t : fetch sequencer states
//   PC_INCR       : byte distance between consecutive instruction words
package isa_shared;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO used for the prefetch buffer and the
// in-order address queue of outstanding requests.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             empties the FIFO; push and pop in the same cycle are ignored
//   push, push_data   write an entry (ignored when full unless a pop frees a slot)
//   pop               remove the head entry (ignored when empty)
//   pop_data          head entry, valid whenever empty is low
//   empty, count      occupancy status; count runs 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0) && !flush;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_push = push && ((cnt != FULL_CNT) || do_pop) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential instruction-memory reads under a
// credit limit, buffers in-order responses with their addresses, and handles
// redirects by flushing the buffer and discarding responses still in flight.
//
//   state | meaning
//   BOOT  | one cycle after reset; no requests, responses ignored
//   RUN   | fetching sequentially from the fetch PC
//   DRAIN | waiting for stale responses of a redirected stream to return
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   redirect_valid, redirect_pc     PC change request from execute
//   imem_req_valid/addr/ready       instruction-memory read request
//   imem_resp_valid/data            in-order read response
//   inst_valid/data/pc, inst_ready  instruction stream to the next stage
module fetch_unit
    import isa_shared::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

    fetch_state_t state, state_next;

    logic [DATA_WIDTH-1:0]   pc, pc_next;
    logic [CW-1:0]           discard, discard_next;
    logic [CW-1:0]           in_flight, in_flight_next;
    logic [CW-1:0]           buf_count;
    logic [CW:0]             credit_used;
    logic                    buf_empty;
    logic                    aq_empty;
    logic [2*DATA_WIDTH-1:0] buf_data;
    logic [DATA_WIDTH-1:0]   resp_pc;
    logic                    redirect;
    logic                    req_ok;
    logic                    fire;
    logic                    resp;
    logic                    drop;
    logic                    keep;
    logic                    pop;

    assign redirect    = redirect_valid && (state != BOOT);
    assign credit_used = {1'b0, in_flight} + {1'b0, buf_count};
    assign req_ok      = (state == RUN) && !redirect_valid && (credit_used < CREDIT_MAX);
    assign fire        = req_ok && imem_req_ready;

    // Responses only count against real outstanding requests; anything seen in
    // BOOT or with nothing in flight belongs to a stream abandoned by reset.
    assign resp = imem_resp_valid && (state != BOOT) && !aq_empty;
    assign drop = resp && (redirect || (discard != '0));
    assign keep = resp && !drop;
    assign pop  = !buf_empty && inst_ready && !redirect;

    always_comb begin
        in_flight_next = in_flight;
        if (fire && !resp) begin
            in_flight_next = in_flight + CW'(1);
        end else if (resp && !fire) begin
            in_flight_next = in_flight - CW'(1);
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;

        if (redirect) begin
            pc_next      = redirect_pc & ~DATA_WIDTH'(3);
            // Everything still outstanding after this cycle is from the old stream.
            discard_next = in_flight_next;
        end else begin
            if (fire) begin
                pc_next = pc + DATA_WIDTH'(PC_INCR);
            end
            if (drop) begin
                discard_next = discard - CW'(1);
            end
        end

        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redirect && (in_flight_next != '0)) state_next = DRAIN;
            DRAIN:   if (discard_next == '0) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            discard <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            discard <= discard_next;
        end
    end

    // The address queue occupancy is the in-flight count: one entry per
    // accepted request, removed when its response returns.
    fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (fire),
        .push_data (pc),
        .pop       (resp),
        .pop_data  (resp_pc),
        .empty     (aq_empty),
        .count     (in_flight)
    );

    fetch_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (keep),
        .push_data ({resp_pc, imem_resp_data}),
        .pop       (pop),
        .pop_data  (buf_data),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign imem_req_valid = req_ok;
    assign imem_req_addr  = req_ok ? pc : '0;
    assign inst_valid     = !buf_empty;
    assign inst_data      = buf_empty ? '0 : buf_data[DATA_WIDTH-1:0];
    assign inst_pc        = buf_empty ? '0 : buf_data[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          imem_req_valid;
    logic [W-1:0]  imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [W-1:0]  imem_resp_data;
    logic          inst_valid;
    logic [W-1:0]  inst_data;
    logic [W-1:0]  inst_pc;
    logic          inst_ready;

    always #5 clk = ~clk;

    fetch_unit #(
        .DATA_WIDTH (W),
        .DEPTH      (D),
        .RESET_PC   (RPC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
    );

    // Reference model: memory holds a fixed word per address; outstanding
    // requests are tagged with the stream epoch they belong to. Responses of an
    // older epoch are stale and must never reach the output.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] obuf[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    bit          boot = 1'b1;
    bit          junk = 1'b0;
    logic [31:0] exp_req_pc;
    int          n_fire = 0;
    int          n_pop = 0;
    logic [31:0] last_fire_addr;
    logic [31:0] last_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model on the
    // falling edge, then advance the model across the rising edge.
    task automatic cycle(input bit ready, input bit iready, input bit redir, input logic [31:0] rpc);
        bit   deliver, ev_rv, ev_iv, fire, pop;
        int   stale, due;
        req_t e;
        deliver         = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_resp_valid = deliver || junk;
        imem_resp_data  = deliver ? mem_word(mq[0].addr) : 32'hBAD0_BAD0;
        imem_req_ready  = ready;
        inst_ready      = iready;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        @(negedge clk);
        stale = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
        ev_rv = !boot && (stale == 0) && !redir && ((mq.size() + obuf.size()) < D);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, ev_rv});
        if (ev_rv) check("req_addr", imem_req_addr, exp_req_pc);
        ev_iv = (obuf.size() != 0);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, ev_iv});
        if (ev_iv) begin
            check("inst_pc", inst_pc, obuf[0]);
            check("inst_data", inst_data, mem_word(obuf[0]));
        end
        fire = ev_rv && ready;
        pop  = ev_iv && iready && !redir;
        @(posedge clk);
        #1;
        if (pop) begin
            last_pop_pc = obuf.pop_front();
            n_pop++;
        end
        if (deliver) begin
            e = mq.pop_front();
            if (!redir && (e.epoch == epoch)) obuf.push_back(e.addr);
        end
        if (fire) begin
            due = cyc + lat;
            if ((mq.size() > 0) && (mq[$].due >= due)) due = mq[$].due + 1;
            e.addr  = exp_req_pc;
            e.epoch = epoch;
            e.due   = due;
            mq.push_back(e);
            last_fire_addr = exp_req_pc;
            n_fire++;
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (redir) begin
            obuf.delete();
            epoch++;
            exp_req_pc = rpc & ~32'h3;
        end
        boot = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b1;
        #1;
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        mq.delete();
        obuf.delete();
        exp_req_pc = RPC;
        boot = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // First cycle after release is BOOT; a stray response must be ignored.
        junk = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, '0);
        junk = 1'b0;
    endtask

    task automatic wait_fire(input string tag);
        int  n0;
        bit  got;
        n0  = n_fire;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            got = (n_fire != n0);
        end
        check({tag, "_seen"}, {31'b0, got}, 32'd1);
    endtask

    task automatic wait_pop(input string tag);
        int  n0;
        bit  got;
        n0  = n_pop;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            got = (n_pop != n0);
        end
        check({tag, "_seen"}, {31'b0, got}, 32'd1);
    endtask

    task automatic run_until_inflight(input int n);
        for (int i = 0; i < 20 && mq.size() != n; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        int n0;
        bit rdy, irdy, rdr;

        // Streaming with a single-cycle memory and an always-ready consumer.
        lat = 1;
        do_reset();
        wait_fire("first_req");
        check("first_req_addr", last_fire_addr, RPC);
        wait_pop("first_out");
        check("first_out_pc", last_pop_pc, RPC);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, '0);
        n0 = n_pop;
        repeat (10) cycle(1'b1, 1'b1, 1'b0, '0);
        check("stream_rate", n_pop - n0, 32'd10);

        // Consumer stalls: the credit limit caps issue at DEPTH requests.
        do_reset();
        n0 = n_fire;
        repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);
        check("stall_fires", n_fire - n0, D);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        n0 = n_pop;
        wait_fire("resume_req");
        check("resume_addr", last_fire_addr, 32'h10);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
        check("resume_pops", {31'b0, (n_pop - n0) >= 4}, 32'd1);

        // Redirect with three requests in flight.
        lat = 3;
        do_reset();
        run_until_inflight(3);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        wait_fire("redir_req");
        check("redir_req_addr", last_fire_addr, 32'h100);
        wait_pop("redir_out");
        check("redir_out_pc", last_pop_pc, 32'h100);

        // Second redirect while still draining the first.
        run_until_inflight(3);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        wait_pop("redir2_out");
        check("redir2_out_pc", last_pop_pc, 32'h200);

        // Fetch PC wraps at the top of the address space.
        lat = 1;
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        wait_fire("wrap_req0");
        check("wrap_addr0", last_fire_addr, 32'hFFFF_FFFC);
        wait_fire("wrap_req1");
        check("wrap_addr1", last_fire_addr, 32'h0);

        // Reset mid-operation with two requests outstanding.
        lat = 2;
        run_until_inflight(2);
        do_reset();
        wait_fire("post_rst_req");
        check("post_rst_addr", last_fire_addr, RPC);
        wait_pop("post_rst_out");
        check("post_rst_pc", last_pop_pc, RPC);

        // Randomised traffic: back-pressure on both sides, variable latency,
        // occasional redirects to arbitrary addresses.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
            rdy  = ($urandom_range(0, 3) != 0);
            irdy = ($urandom_range(0, 3) != 0);
            rdr  = ($urandom_range(0, 24) == 0);
            cycle(rdy, irdy, rdr, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
